// File: rtl/wtg_predictor.sv
// wtg_predictor: direct-mapped BTB next-PC predictor with a registered execute-side resolve, redirect and training path.
// Optional perf counters are built when WTG_PERF_EN is defined; otherwise perf_* are tied to zero.
`ifndef WTG_OP_BIT
`define WTG_OP_BIT  4
`define WTG_OP_NOP  4'd0
`define WTG_OP_J32  4'd1
`define WTG_OP_J26  4'd2
`define WTG_OP_BEQ  4'd3
`define WTG_OP_BNE  4'd4
`define WTG_OP_BLEZ 4'd5
`define WTG_OP_BGTZ 4'd6
`define WTG_OP_BLTZ 4'd7
`define WTG_OP_BGEZ 4'd8
`define WTG_OP_ALU  4'd9
`endif

module wtg_predictor #(
    parameter int unsigned ENTRIES  = 16,
    parameter logic [1:0]  CTR_INIT = 2'b10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            f_pc,
    output logic [31:0]            f_pred_pc,
    output logic                   f_pred_taken,
    input  logic                   r_valid,
    input  logic [`WTG_OP_BIT-1:0] r_op,
    input  logic [31:0]            r_pc,
    input  logic [31:0]            r_pred_pc,
    input  logic [31:0]            r_off32,
    input  logic [25:0]            r_imm26,
    input  logic [31:0]            r_data_x,
    input  logic [31:0]            r_data_y,
    output logic                   redirect_valid,
    output logic [31:0]            redirect_pc,
    output logic                   branched,
    output logic [31:0]            perf_branches,
    output logic [31:0]            perf_mispredicts
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] uncond_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic             f_hit;

    always_comb begin
        f_idx        = f_pc[IDX_W+1:2];
        f_hit        = valid_q[f_idx] && (tag_q[f_idx] == f_pc[31:IDX_W+2]);
        f_pred_taken = f_hit && (uncond_q[f_idx] || ctr_q[f_idx][1]);
        f_pred_pc    = f_pred_taken ? target_q[f_idx] : f_pc + 32'd4;
    end

    logic [31:0]      pc_4;
    logic [31:0]      br_tgt;
    logic [31:0]      actual;
    logic             is_jump;
    logic             is_cond;
    logic             cond_taken;
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             r_hit;

    always_comb begin
        pc_4       = r_pc + 32'd4;
        br_tgt     = pc_4 + (r_off32 << 2);
        is_jump    = 1'b0;
        is_cond    = 1'b0;
        cond_taken = 1'b0;
        actual     = pc_4;
        case (r_op)
            `WTG_OP_J32: begin
                is_jump = 1'b1;
                actual  = r_data_x;
            end
            `WTG_OP_J26: begin
                is_jump = 1'b1;
                actual  = {pc_4[31:28], r_imm26, 2'b00};
            end
            `WTG_OP_BEQ: begin
                is_cond    = 1'b1;
                cond_taken = (r_data_x == r_data_y);
            end
            `WTG_OP_BNE: begin
                is_cond    = 1'b1;
                cond_taken = (r_data_x != r_data_y);
            end
            `WTG_OP_BLEZ: begin
                is_cond    = 1'b1;
                cond_taken = ($signed(r_data_x) <= $signed(r_data_y));
            end
            `WTG_OP_BGTZ: begin
                is_cond    = 1'b1;
                cond_taken = ($signed(r_data_x) > $signed(r_data_y));
            end
            `WTG_OP_BLTZ: begin
                is_cond    = 1'b1;
                cond_taken = ($signed(r_data_x) < $signed(r_data_y));
            end
            `WTG_OP_BGEZ: begin
                is_cond    = 1'b1;
                cond_taken = ($signed(r_data_x) >= $signed(r_data_y));
            end
            default: ;
        endcase
        if (cond_taken) actual = br_tgt;
        r_idx = r_pc[IDX_W+1:2];
        r_tag = r_pc[31:IDX_W+2];
        r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    end

    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q,    redirect_pc_d;
    logic        branched_q,       branched_d;

    always_comb begin
        redirect_valid_d = r_valid && (actual != r_pred_pc);
        redirect_pc_d    = r_valid ? actual : redirect_pc_q;
        branched_d       = r_valid && is_cond && cond_taken;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            branched_q       <= 1'b0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            branched_q       <= branched_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign branched       = branched_q;

    // Miss allocation overwrites whatever aliased entry sits at the index.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            uncond_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (r_valid && (is_jump || is_cond)) begin
            if (r_hit) begin
                if (is_jump) begin
                    target_q[r_idx] <= actual;
                end else if (cond_taken) begin
                    target_q[r_idx] <= actual;
                    if (ctr_q[r_idx] != 2'b11) ctr_q[r_idx] <= ctr_q[r_idx] + 2'd1;
                end else if (ctr_q[r_idx] != 2'b00) begin
                    ctr_q[r_idx] <= ctr_q[r_idx] - 2'd1;
                end
            end else if (is_jump || cond_taken) begin
                valid_q[r_idx]  <= 1'b1;
                uncond_q[r_idx] <= is_jump;
                tag_q[r_idx]    <= r_tag;
                target_q[r_idx] <= actual;
                ctr_q[r_idx]    <= is_jump ? 2'b11 : CTR_INIT;
            end
        end
    end

`ifdef WTG_PERF_EN
    logic [31:0] perf_br_q;
    logic [31:0] perf_mp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            if (r_valid && (is_jump || is_cond)) perf_br_q <= perf_br_q + 32'd1;
            if (redirect_valid_d) perf_mp_q <= perf_mp_q + 32'd1;
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mp_q;
`else
    assign perf_branches    = '0;
    assign perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_wtg_predictor.sv
// Self-checking bench for wtg_predictor: directed vector table, hand sequences, then random traffic vs. a behavioural model.
`timescale 1ns/1ps
`ifndef WTG_OP_BIT
`define WTG_OP_BIT  4
`define WTG_OP_NOP  4'd0
`define WTG_OP_J32  4'd1
`define WTG_OP_J26  4'd2
`define WTG_OP_BEQ  4'd3
`define WTG_OP_BNE  4'd4
`define WTG_OP_BLEZ 4'd5
`define WTG_OP_BGTZ 4'd6
`define WTG_OP_BLTZ 4'd7
`define WTG_OP_BGEZ 4'd8
`define WTG_OP_ALU  4'd9
`endif

module tb_wtg_predictor;
    localparam int unsigned ENTRIES = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] f_pc;
    logic [31:0] f_pred_pc;
    logic        f_pred_taken;
    logic        r_valid;
    logic [`WTG_OP_BIT-1:0] r_op;
    logic [31:0] r_pc, r_pred_pc, r_off32, r_data_x, r_data_y;
    logic [25:0] r_imm26;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        branched;
    logic [31:0] perf_branches, perf_mispredicts;

    always #5 clk = ~clk;

    wtg_predictor #(.ENTRIES(ENTRIES), .CTR_INIT(2'b10)) dut (
        .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_pc(f_pred_pc), .f_pred_taken(f_pred_taken),
        .r_valid(r_valid), .r_op(r_op), .r_pc(r_pc), .r_pred_pc(r_pred_pc), .r_off32(r_off32),
        .r_imm26(r_imm26), .r_data_x(r_data_x), .r_data_y(r_data_y),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .branched(branched),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one record per slot holding the full PC it learned from.
    typedef struct { bit v; bit u; bit [31:0] pc; bit [31:0] tgt; int ctr; } ent_t;
    ent_t tbl [ENTRIES];
    bit [31:0] m_rv, m_rpc, m_br, m_pb, m_pm;

    function automatic int slot(input bit [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic bit m_hit(input bit [31:0] pc);
        int s = slot(pc);
        return tbl[s].v && ((tbl[s].pc / 4) == (pc / 4));
    endfunction

    function automatic void m_predict(input bit [31:0] pc, output bit [31:0] npc, output bit tk);
        int s = slot(pc);
        tk  = m_hit(pc) && (tbl[s].u || tbl[s].ctr >= 2);
        npc = tk ? tbl[s].tgt : pc + 4;
    endfunction

    function automatic void m_resolve(input bit [3:0] op, input bit [31:0] pc, input bit [31:0] off,
                                      input bit [25:0] imm, input bit [31:0] x, input bit [31:0] y,
                                      output bit [31:0] act, output bit isj, output bit isc, output bit tk);
        int sx = x;
        int sy = y;
        bit [31:0] pc4 = pc + 4;
        isj = (op == `WTG_OP_J32) || (op == `WTG_OP_J26);
        isc = (op >= `WTG_OP_BEQ) && (op <= `WTG_OP_BGEZ);
        tk  = isj;
        act = pc4;
        case (op)
            `WTG_OP_J32:  act = x;
            `WTG_OP_J26:  act = (pc4 & 32'hF000_0000) + 32'(imm) * 4;
            `WTG_OP_BEQ:  tk = (sx == sy);
            `WTG_OP_BNE:  tk = (sx != sy);
            `WTG_OP_BLEZ: tk = (sx <= sy);
            `WTG_OP_BGTZ: tk = (sx > sy);
            `WTG_OP_BLTZ: tk = (sx < sy);
            `WTG_OP_BGEZ: tk = (sx >= sy);
            default: ;
        endcase
        if (isc && tk) act = pc4 + off * 4;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < ENTRIES; i++) tbl[i] = '{0, 0, 0, 0, 0};
    endtask

    task automatic m_step();
        bit [31:0] act;
        bit isj, isc, tk;
        int s;
        if (rst) begin
            m_clear();
            m_rv = 0; m_rpc = 0; m_br = 0; m_pb = 0; m_pm = 0;
        end else if (!r_valid) begin
            m_rv = 0; m_br = 0;
        end else begin
            m_resolve(r_op, r_pc, r_off32, r_imm26, r_data_x, r_data_y, act, isj, isc, tk);
            m_rv  = (act != r_pred_pc);
            m_rpc = act;
            m_br  = isc && tk;
            if (isj || isc) m_pb++;
            if (m_rv) m_pm++;
            s = slot(r_pc);
            if ((isj || isc) && m_hit(r_pc)) begin
                if (isj) tbl[s].tgt = act;
                else if (tk) begin
                    tbl[s].tgt = act;
                    tbl[s].ctr = (tbl[s].ctr < 3) ? tbl[s].ctr + 1 : 3;
                end else tbl[s].ctr = (tbl[s].ctr > 0) ? tbl[s].ctr - 1 : 0;
            end else if (isj || (isc && tk)) begin
                tbl[s] = '{1, isj, r_pc, act, isj ? 3 : 2};
            end
        end
    endtask

    // Inputs are held from one edge+1 to the next; model commits right after the edge.
    task automatic do_cycle();
        bit [31:0] ppc;
        bit ptk;
        #1;
        m_predict(f_pc, ppc, ptk);
        chk("f_pred_pc", f_pred_pc, ppc);
        chk("f_pred_taken", {31'b0, f_pred_taken}, {31'b0, ptk});
        @(posedge clk);
        #1;
        m_step();
        chk("redirect_valid", {31'b0, redirect_valid}, m_rv);
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("branched", {31'b0, branched}, m_br);
`ifdef WTG_PERF_EN
        chk("perf_branches", perf_branches, m_pb);
        chk("perf_mispredicts", perf_mispredicts, m_pm);
`else
        chk("perf_branches", perf_branches, 32'd0);
        chk("perf_mispredicts", perf_mispredicts, 32'd0);
`endif
    endtask

    task automatic set_r(input bit vld, input bit [3:0] op, input bit [31:0] pc, input bit [31:0] pred,
                         input bit [31:0] off, input bit [25:0] imm, input bit [31:0] x, input bit [31:0] y);
        r_valid = vld; r_op = op; r_pc = pc; r_pred_pc = pred;
        r_off32 = off; r_imm26 = imm; r_data_x = x; r_data_y = y;
    endtask

    function automatic bit [31:0] pick_pc();
        return 32'h0040_0000 + (32'($urandom_range(0, 3)) << 12) + (32'($urandom_range(0, 15)) << 2);
    endfunction

    typedef struct {
        bit vld; bit [3:0] op; bit [31:0] pc; bit [31:0] pred; bit [31:0] off; bit [25:0] imm;
        bit [31:0] x; bit [31:0] y; bit [31:0] fpc;
        bit [31:0] e_ppc; bit e_ptk; bit e_rv; bit [31:0] e_rpc; bit e_br;
    } vec_t;
    vec_t vt [$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vt.push_back('{1, `WTG_OP_BEQ, 32'h0040_0010, 32'h0040_0014, 32'd3, 26'h0, 32'd5, 32'd5, 32'h0040_0010, 32'h0040_0014, 0, 1, 32'h0040_0020, 1});
        vt.push_back('{1, `WTG_OP_BEQ, 32'h0040_0010, 32'h0040_0020, 32'd3, 26'h0, 32'd1, 32'd2, 32'h0040_0010, 32'h0040_0020, 1, 1, 32'h0040_0014, 0});
        vt.push_back('{1, `WTG_OP_BEQ, 32'h0040_0010, 32'h0040_0020, 32'd3, 26'h0, 32'd1, 32'd2, 32'h0040_0010, 32'h0040_0014, 0, 1, 32'h0040_0014, 0});
        vt.push_back('{0, `WTG_OP_NOP, 32'h0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0, 32'h0040_0010, 32'h0040_0014, 0, 0, 32'h0040_0014, 0});
        vt.push_back('{1, `WTG_OP_J26, 32'h1000_0000, 32'h1000_0004, 32'h0, 26'h100, 32'h0, 32'h0, 32'h1000_0000, 32'h1000_0004, 0, 1, 32'h1000_0400, 0});
        vt.push_back('{0, `WTG_OP_NOP, 32'h0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0, 32'h1000_0000, 32'h1000_0400, 1, 0, 32'h1000_0400, 0});
        vt.push_back('{1, `WTG_OP_J26, 32'h1000_0000, 32'h1000_0400, 32'h0, 26'h100, 32'h0, 32'h0, 32'h1000_0000, 32'h1000_0400, 1, 0, 32'h1000_0400, 0});
        vt.push_back('{1, `WTG_OP_J32, 32'h0040_0100, 32'h0040_0104, 32'h0, 26'h0, 32'h0040_1234, 32'h0, 32'h0040_0100, 32'h0040_0104, 0, 1, 32'h0040_1234, 0});
        vt.push_back('{1, `WTG_OP_ALU, 32'h0040_0200, 32'h0040_0204, 32'h0, 26'h0, 32'h0, 32'h0, 32'h0040_0100, 32'h0040_1234, 1, 0, 32'h0040_0204, 0});
        vt.push_back('{1, `WTG_OP_ALU, 32'h0040_0200, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0, 32'h0040_0200, 32'h0040_0204, 0, 1, 32'h0040_0204, 0});
        vt.push_back('{1, `WTG_OP_BLTZ, 32'h0040_0300, 32'h0040_0304, 32'hFFFF_FFFE, 26'h0, 32'hFFFF_FFFF, 32'd1, 32'h0040_0300, 32'h0040_0304, 0, 1, 32'h0040_02FC, 1});
        vt.push_back('{1, `WTG_OP_BGEZ, 32'h0040_0400, 32'h0040_0404, 32'd8, 26'h0, 32'hFFFF_FFFB, 32'd3, 32'h0040_0300, 32'h0040_02FC, 1, 0, 32'h0040_0404, 0});
        vt.push_back('{0, `WTG_OP_NOP, 32'h0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0, 32'h1000_0000, 32'h1000_0004, 0, 0, 32'h0040_0404, 0});

        rst = 1'b1;
        f_pc = 32'h0040_0000;
        set_r(0, `WTG_OP_NOP, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        m_step();
        rst = 1'b0;
        #1;
        chk("reset_pred_pc", f_pred_pc, 32'h0040_0004);
        chk("reset_pred_taken", {31'b0, f_pred_taken}, 32'd0);
        chk("reset_redirect_valid", {31'b0, redirect_valid}, 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);
        chk("reset_branched", {31'b0, branched}, 32'd0);
        chk("reset_perf_branches", perf_branches, 32'd0);
        chk("reset_perf_mispredicts", perf_mispredicts, 32'd0);

        foreach (vt[i]) begin
            set_r(vt[i].vld, vt[i].op, vt[i].pc, vt[i].pred, vt[i].off, vt[i].imm, vt[i].x, vt[i].y);
            f_pc = vt[i].fpc;
            #1;
            chk($sformatf("v%0d_pred_pc", i), f_pred_pc, vt[i].e_ppc);
            chk($sformatf("v%0d_pred_taken", i), {31'b0, f_pred_taken}, {31'b0, vt[i].e_ptk});
            do_cycle();
            chk($sformatf("v%0d_redirect_valid", i), {31'b0, redirect_valid}, {31'b0, vt[i].e_rv});
            chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vt[i].e_rpc);
            chk($sformatf("v%0d_branched", i), {31'b0, branched}, {31'b0, vt[i].e_br});
        end

        // Counter saturation both ways: T,T,T,T (sat 3), NT x5 (sat 0), T,T -> ctr 2.
        f_pc = 32'h0040_0600;
        for (int i = 0; i < 11; i++) begin
            if (i < 4 || i >= 9) set_r(1, `WTG_OP_BNE, 32'h0040_0600, 32'h0040_0604, 32'd4, 0, 32'd1, 32'd2);
            else                 set_r(1, `WTG_OP_BNE, 32'h0040_0600, 32'h0040_0604, 32'd4, 0, 32'd7, 32'd7);
            do_cycle();
        end
        set_r(0, `WTG_OP_NOP, 0, 0, 0, 0, 0, 0);
        #1;
        chk("sat_pred_taken", {31'b0, f_pred_taken}, 32'd1);
        chk("sat_pred_pc", f_pred_pc, 32'h0040_0614);

        // Mispredict, then reset on the next cycle while a resolve is also presented.
        set_r(1, `WTG_OP_BEQ, 32'h0040_0500, 32'h0040_0504, 32'd1, 0, 32'd9, 32'd9);
        do_cycle();
        chk("pre_rst_redirect_valid", {31'b0, redirect_valid}, 32'd1);
        rst = 1'b1;
        set_r(1, `WTG_OP_J26, 32'h2000_0000, 32'h0, 0, 26'h40, 0, 0);
        do_cycle();
        chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_branched", {31'b0, branched}, 32'd0);
        chk("rst_perf_branches", perf_branches, 32'd0);
        chk("rst_perf_mispredicts", perf_mispredicts, 32'd0);
        rst = 1'b0;
        set_r(0, `WTG_OP_NOP, 0, 0, 0, 0, 0, 0);
        f_pc = 32'h0040_0500;
        #1;
        chk("rst_table_empty_a", f_pred_pc, 32'h0040_0504);
        f_pc = 32'h2000_0000;
        #1;
        chk("rst_table_ignored_r", f_pred_pc, 32'h2000_0004);
        do_cycle();

        for (int k = 0; k < 3000; k++) begin
            bit [31:0] ppc, act;
            bit ptk, isj, isc, tk;
            rst      = ($urandom_range(0, 299) == 0);
            r_valid  = ($urandom_range(0, 9) < 8);
            r_op     = 4'($urandom_range(0, 9));
            r_pc     = pick_pc();
            r_off32  = $urandom_range(0, 63) - 32'd32;
            r_imm26  = 26'($urandom);
            r_data_x = (r_op == `WTG_OP_J32 && $urandom_range(0, 1) == 1) ? pick_pc() : $urandom_range(0, 4) - 32'd2;
            r_data_y = $urandom_range(0, 4) - 32'd2;
            m_predict(r_pc, ppc, ptk);
            m_resolve(r_op, r_pc, r_off32, r_imm26, r_data_x, r_data_y, act, isj, isc, tk);
            case ($urandom_range(0, 2))
                0:       r_pred_pc = ppc;
                1:       r_pred_pc = act;
                default: r_pred_pc = $urandom;
            endcase
            f_pc = ($urandom_range(0, 1) == 1) ? r_pc : pick_pc();
            do_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wtg_predictor.md
Name: wtg_predictor

Overview:
- Sequential successor to the combinational next-PC unit.
- Fetch side: direct-mapped branch target buffer (BTB) with 2-bit saturating counters gives a predicted next PC, combinationally from registered state.
- Execute side: resolves the actual next PC using the existing WTG_OP_* semantics, compares it with the prediction carried down the pipe, issues a registered redirect and trains the table.
- Sits between the PC register (fetch) and the EX stage of the core.

Parameters:
- ENTRIES, 16, BTB entry count; power of two, at least 2. IDX_W = log2(ENTRIES).
- CTR_INIT, 2'b10, counter value written when a conditional branch is allocated.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- f_pc  in  32  fetch PC
- f_pred_pc  out  32  predicted next PC (combinational)
- f_pred_taken  out  1  prediction was a taken BTB hit
- r_valid  in  1  resolve request valid this cycle
- r_op  in  `WTG_OP_BIT  WTG_OP_* code from Core.vh
- r_pc  in  32  PC of the resolving instruction
- r_pred_pc  in  32  f_pred_pc captured when this instruction was fetched
- r_off32  in  32  sign-extended branch offset
- r_imm26  in  26  jump immediate
- r_data_x  in  32  signed operand x
- r_data_y  in  32  signed operand y
- redirect_valid  out  1  registered mispredict strobe
- redirect_pc  out  32  correct next PC
- branched  out  1  registered; conditional branch taken
- perf_branches  out  32  resolved control-transfer count
- perf_mispredicts  out  32  mispredict count

Behaviour:
- Entry fields: valid, uncond, tag = pc[31:IDX_W+2], target[31:0], ctr[1:0]. Index = pc[IDX_W+1:2].
- Predict:
  - hit = valid && tag match.
  - f_pred_taken = hit && (uncond || ctr[1]).
  - f_pred_pc = f_pred_taken ? target : f_pc+4.
- Actual next PC, with pc_4 = r_pc+4:
  - J32 -> data_x.
  - J26 -> {pc_4[31:28], imm26, 2'b00}.
  - BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ -> signed compare on data_x/data_y; taken -> {off32[29:0], 2'b00} + pc_4, else pc_4.
  - Any other op -> pc_4, never trains.
  - All adds are modulo 2^32.
- Resolve:
  - Latency 1 cycle; outputs registered at the edge after r_valid.
  - When r_valid: redirect_valid <= (actual != r_pred_pc); redirect_pc <= actual; branched <= conditional && taken.
  - When !r_valid: redirect_valid <= 0 and branched <= 0; redirect_pc holds.
  - redirect_valid is a single-cycle pulse per mispredicting resolve. Back-to-back resolves each produce their own pulse.
- Training (only on r_valid with a J/B op), at the same edge:
  - Hit, conditional: taken -> ctr saturating increment (max 3) and target <= actual; not-taken -> saturating decrement (min 0).
  - Hit, jump: target <= actual.
  - Miss, taken: allocate and overwrite unconditionally. Jumps get uncond=1, ctr=3; conditionals get uncond=0, ctr=CTR_INIT.
  - Miss, not taken: no write.
- Same-index predict and update in one cycle: predict reads the pre-update contents; the write is visible the next cycle.
- Reset (including mid-operation):
  - All valid bits cleared; ctr, uncond and target cleared.
  - redirect_valid = 0, redirect_pc = 0, branched = 0, perf counters = 0.
  - A pending redirect is dropped.
  - r_valid is ignored during the reset cycle.

Optional Feature:
- Macro: WTG_PERF_EN.
- Defined:
  - perf_branches increments on every r_valid with a J/B op.
  - perf_mispredicts increments on every r_valid with actual != r_pred_pc.
  - Both are 32-bit, wrap modulo 2^32, cleared by rst, updated at the same edge as the redirect.
- Undefined: counters are not built; both ports are driven constant 0. The port list is unchanged.

Test Plan:
- Reset, then f_pc=0x0040_0000 -> f_pred_pc=0x0040_0004, f_pred_taken=0; all registered outputs 0.
- Cold BEQ at r_pc=0x0040_0010, off32=3, x=y=5, r_pred_pc=0x0040_0014 -> next cycle redirect_valid=1, redirect_pc=0x0040_0020, branched=1. Entry allocated with ctr=2, so f_pc=0x0040_0010 then predicts 0x0040_0020.
- Same BEQ resolved not-taken twice (x=1, y=2) -> ctr goes 2->1->0. Each resolve redirects to 0x0040_0014; the prediction then falls through to 0x0040_0014.
- J26 at r_pc=0x1000_0000, imm26=0x0000100 -> redirect_pc=0x1000_0400. The entry becomes uncond and is predicted taken from the next cycle. Same-cycle fetch of that PC still sees a miss.
- Correct prediction with r_pred_pc equal to the actual PC -> redirect_valid=0. Under WTG_PERF_EN, perf_branches increments and perf_mispredicts is unchanged.
- Assert rst on the cycle after a mispredicting resolve -> redirect_valid=0, table empty, perf counters 0.
